// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-source packet arbiter in front of
// the 8-bit 2:1 data mux.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } arb_state_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux_8bit_arbiter_if.sv
// Producer A/B inputs plus the registered output stage of the arbiter.
// slave is the arbiter's view; master is the view of the producers and consumer.
interface mux_8bit_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_last;
   logic             a_ready;

   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_last;
   logic             b_ready;

   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_sel;
   logic             out_ready;

   modport slave (
      input  a_valid, a_data, a_last,
      output a_ready,
      input  b_valid, b_data, b_last,
      output b_ready,
      output out_valid, out_data, out_last, out_sel,
      input  out_ready
   );

   modport master (
      output a_valid, a_data, a_last,
      input  a_ready,
      output b_valid, b_data, b_last,
      input  b_ready,
      input  out_valid, out_data, out_last, out_sel,
      output out_ready
   );
endinterface

// File: rtl/mux_arb_out_reg.sv
// One-entry output register with valid/ready; refills in the same cycle it
// drains so the arbiter sustains one beat per clock.
module mux_arb_out_reg
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_sel,
   input  logic             out_ready,
   output logic             can_accept,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_sel
);

   assign can_accept = !out_valid || out_ready;

   // Drain alone only clears valid; the payload holds its last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= SRC_A;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_last  <= in_last;
         out_sel   <= in_sel;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mux_8bit_arbiter.sv
// Round-robin, packet-locked arbiter between sources A and B; the registered
// out_sel drives the downstream 2:1 data mux select.
module mux_8bit_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   mux_8bit_arbiter_if.slave   bus
);

   arb_state_t       state_reg;
   logic             rr_ptr_reg;
   logic             grant_a;
   logic             grant_b;
   logic             can_accept;
   logic             accept_a;
   logic             accept_b;
   logic             load;
   logic             sel_next;
   logic             last_next;
   logic [WIDTH-1:0] data_next;

   // A lock grants its owner even while it is idle, so the other side
   // can never slip a beat into the middle of a packet.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      case (state_reg)
         LOCK_A: grant_a = 1'b1;
         LOCK_B: grant_b = 1'b1;
         default: begin
            if (bus.a_valid && bus.b_valid) begin
               if (rr_ptr_reg == SRC_B) grant_a = 1'b1;
               else                     grant_b = 1'b1;
            end else begin
               grant_a = bus.a_valid;
               grant_b = bus.b_valid;
            end
         end
      endcase
   end

   assign bus.a_ready = !rst && can_accept && grant_a;
   assign bus.b_ready = !rst && can_accept && grant_b;

   assign accept_a  = bus.a_valid && bus.a_ready;
   assign accept_b  = bus.b_valid && bus.b_ready;
   assign load      = accept_a || accept_b;
   assign sel_next  = accept_b ? SRC_B : SRC_A;
   assign data_next = accept_b ? bus.b_data : bus.a_data;
   assign last_next = accept_b ? bus.b_last : bus.a_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= SRC_B;
      end else if (load) begin
         rr_ptr_reg <= sel_next;
         case (state_reg)
            IDLE: begin
               if (!last_next) state_reg <= (sel_next == SRC_B) ? LOCK_B : LOCK_A;
            end
            LOCK_A, LOCK_B: begin
               if (last_next) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   mux_arb_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .in_data    (data_next),
      .in_last    (last_next),
      .in_sel     (sel_next),
      .out_ready  (bus.out_ready),
      .can_accept (can_accept),
      .out_valid  (bus.out_valid),
      .out_data   (bus.out_data),
      .out_last   (bus.out_last),
      .out_sel    (bus.out_sel)
   );

endmodule
